// File: rtl/mem_pkg.sv
// Shared memory-subsystem constants: block index width, write-port count and
// free-list prefetch depth used by the allocation arbiter.
package mem_pkg;

  localparam int ADDR_W      = 8;
  localparam int NUM_PORTS   = 4;
  localparam int FL_PF_DEPTH = 2;

endpackage : mem_pkg

// File: rtl/fl_prefetch_fifo.sv
// Small synchronous FIFO holding free block indices that were already popped
// from the free list, so grants do not wait for free-list read latency.
module fl_prefetch_fifo #(
  parameter int DEPTH = mem_pkg::FL_PF_DEPTH,
  parameter int W     = mem_pkg::ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q;
  logic [PTR_W-1:0] rptr_q;
  logic [CNT_W-1:0] count_q;

  // Storage write; contents need no reset because count_q gates visibility.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wptr_q] <= data_i;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        wptr_q <= wptr_q + PTR_ONE;
      end
      if (pop_i) begin
        rptr_q <= rptr_q + PTR_ONE;
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;

endmodule : fl_prefetch_fifo

// File: rtl/fl_alloc_arbiter.sv
// Shares the single free-list pop port among NUM_PORTS write controllers.
// A prefetch FIFO keeps free block indices ready; a round-robin scan hands one
// index out per one-cycle grant pulse.
module fl_alloc_arbiter #(
  parameter int NUM_PORTS = mem_pkg::NUM_PORTS,
  parameter int PF_DEPTH  = mem_pkg::FL_PF_DEPTH,
  parameter int ADDR_W    = mem_pkg::ADDR_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORTS-1:0]          req_i,
  input  logic [NUM_PORTS-1:0]          port_en_i,
  output logic [NUM_PORTS-1:0]          gnt_o,
  output logic [ADDR_W-1:0]             alloc_block_idx_o,
  input  logic                          fl_empty_i,
  output logic                          fl_pop_o,
  input  logic [ADDR_W-1:0]             fl_rdata_i,
  output logic [$clog2(PF_DEPTH):0]     pf_count_o
);

  localparam int CNT_W = $clog2(PF_DEPTH) + 1;
  localparam int RR_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [CNT_W:0]     PF_LIMIT = (CNT_W + 1)'(PF_DEPTH);
  localparam logic [RR_W-1:0]    RR_LAST  = RR_W'(NUM_PORTS - 1);
  localparam logic [RR_W-1:0]    RR_ONE   = RR_W'(1);
  localparam logic [NUM_PORTS-1:0] GNT_ONE = NUM_PORTS'(1);

  logic                 inflight_q;
  logic [NUM_PORTS-1:0] gnt_q;
  logic [NUM_PORTS-1:0] gnt_d;
  logic [ADDR_W-1:0]    idx_q;
  logic [ADDR_W-1:0]    idx_d;
  logic [RR_W-1:0]      rr_q;
  logic [RR_W-1:0]      rr_d;

  logic [CNT_W-1:0]     pf_count_s;
  logic [ADDR_W-1:0]    pf_head_s;
  logic [CNT_W:0]       pending_s;
  logic [NUM_PORTS-1:0] elig_s;
  logic                 found_s;
  logic [RR_W-1:0]      winner_s;
  logic                 grant_fire_s;
  int                   cand_s;

  fl_prefetch_fifo #(
    .DEPTH (PF_DEPTH),
    .W     (ADDR_W)
  ) u_pf_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (inflight_q),
    .data_i  (fl_rdata_i),
    .pop_i   (grant_fire_s),
    .head_o  (pf_head_s),
    .count_o (pf_count_s)
  );

  // Indices already held plus the one on its way; never ask for more than fits.
  assign pending_s = {1'b0, pf_count_s} + {{CNT_W{1'b0}}, inflight_q};
  assign fl_pop_o  = rst_n & ~fl_empty_i & (pending_s < PF_LIMIT);

  // A port being granted right now is held off: its request is still high
  // for this cycle and would otherwise earn a second block.
  assign elig_s = req_i & port_en_i & ~gnt_q;

  // Round-robin scan: first eligible port at or after rr_q, modulo NUM_PORTS.
  always_comb begin
    found_s  = 1'b0;
    winner_s = '0;
    cand_s   = 0;
    for (int off = 0; off < NUM_PORTS; off++) begin
      cand_s = (int'(rr_q) + off) % NUM_PORTS;
      if (!found_s && elig_s[cand_s]) begin
        found_s  = 1'b1;
        winner_s = RR_W'(cand_s);
      end else begin
        found_s  = found_s;
      end
    end
  end

  assign grant_fire_s = found_s & (pf_count_s != '0);

  // Next-state for grant pulse, granted index and priority pointer.
  always_comb begin
    gnt_d = '0;
    idx_d = idx_q;
    rr_d  = rr_q;
    if (grant_fire_s) begin
      gnt_d = GNT_ONE << winner_s;
      idx_d = pf_head_s;
      if (winner_s == RR_LAST) begin
        rr_d = '0;
      end else begin
        rr_d = winner_s + RR_ONE;
      end
    end else begin
      gnt_d = '0;
    end
  end

  // Registered grant/index outputs, priority pointer and in-flight pop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q      <= '0;
      idx_q      <= '0;
      rr_q       <= '0;
      inflight_q <= 1'b0;
    end else begin
      gnt_q      <= gnt_d;
      idx_q      <= idx_d;
      rr_q       <= rr_d;
      inflight_q <= fl_pop_o;
    end
  end

  assign gnt_o             = gnt_q;
  assign alloc_block_idx_o = idx_q;
  assign pf_count_o        = pf_count_s;

endmodule : fl_alloc_arbiter

// File: tb/tb_fl_alloc_arbiter.sv
// Randomised and directed bench for fl_alloc_arbiter against a queue-based
// behavioural model of the prefetch/round-robin allocation rules.
module tb_fl_alloc_arbiter;

  localparam int N  = 4;
  localparam int PF = 2;
  localparam int AW = 8;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req_i;
  logic [N-1:0]  port_en_i;
  logic [N-1:0]  gnt_o;
  logic [AW-1:0] alloc_block_idx_o;
  logic          fl_empty_i;
  logic          fl_pop_o;
  logic [AW-1:0] fl_rdata_i;
  logic [1:0]    pf_count_o;

  fl_alloc_arbiter #(.NUM_PORTS(N), .PF_DEPTH(PF), .ADDR_W(AW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_i             (req_i),
    .port_en_i         (port_en_i),
    .gnt_o             (gnt_o),
    .alloc_block_idx_o (alloc_block_idx_o),
    .fl_empty_i        (fl_empty_i),
    .fl_pop_o          (fl_pop_o),
    .fl_rdata_i        (fl_rdata_i),
    .pf_count_o        (pf_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: queue of prefetched indices, pop in flight,
  // next port to favour, and what the outputs must show this cycle.
  int          m_q[$];
  bit          m_infl;
  int          m_rr;
  logic [N-1:0]  m_gnt;
  logic [AW-1:0] m_idx;
  int          fl_next;
  logic [AW-1:0] pend_data;
  logic [N-1:0]  cur_req;
  logic [N-1:0]  prev_gnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_infl = 1'b0;
    m_rr   = 0;
    m_gnt  = '0;
    m_idx  = '0;
  endtask

  // One clock cycle: drive inputs at the negedge, check outputs, then
  // advance the model across the coming posedge.
  task automatic do_cycle(input logic [N-1:0] r, input logic [N-1:0] en, input bit emp);
    bit   exp_pop;
    bit   won;
    int   w;
    logic [N-1:0] elig;
    @(negedge clk);
    rst_n      = 1'b1;
    req_i      = r;
    port_en_i  = en;
    fl_empty_i = emp;
    fl_rdata_i = m_infl ? pend_data : AW'($urandom);
    #1;
    exp_pop = !emp && ((m_q.size() + int'(m_infl)) < PF);
    chk("gnt", 32'(gnt_o), 32'(m_gnt));
    chk("idx", 32'(alloc_block_idx_o), 32'(m_idx));
    chk("pf_count", 32'(pf_count_o), 32'(m_q.size()));
    chk("fl_pop", 32'(fl_pop_o), 32'(exp_pop));
    // arbitration uses this cycle's grant as holdoff
    elig = r & en & ~m_gnt;
    won  = 1'b0;
    w    = 0;
    if (m_q.size() > 0) begin
      for (int k = 0; k < N; k++) begin
        if (!won && elig[(m_rr + k) % N]) begin
          won = 1'b1;
          w   = (m_rr + k) % N;
        end
      end
    end
    prev_gnt = m_gnt;
    if (won) begin
      m_gnt = '0;
      m_gnt[w] = 1'b1;
      m_idx = AW'(m_q.pop_front());
      m_rr  = (w + 1) % N;
    end else begin
      m_gnt = '0;
    end
    if (m_infl) m_q.push_back(int'(pend_data));
    if (exp_pop) begin
      pend_data = AW'(fl_next);
      fl_next++;
    end
    m_infl = exp_pop;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    chk("rst_idx", 32'(alloc_block_idx_o), 32'd0);
    chk("rst_pf_count", 32'(pf_count_o), 32'd0);
    chk("rst_fl_pop", 32'(fl_pop_o), 32'd0);
    model_reset();
    cur_req  = '0;
    prev_gnt = '0;
    @(negedge clk);
    #1;
    chk("rst_hold_fl_pop", 32'(fl_pop_o), 32'd0);
  endtask

  // Requesters that hold their request until served and drop it one cycle
  // after the grant pulse.
  task automatic rand_cycle();
    logic [N-1:0] en;
    for (int i = 0; i < N; i++) begin
      if (prev_gnt[i]) cur_req[i] = 1'b0;
      else if (!cur_req[i] && !m_gnt[i]) cur_req[i] = ($urandom_range(0, 2) == 0);
    end
    en = ($urandom_range(0, 5) == 0) ? N'($urandom) : 4'b1111;
    do_cycle(cur_req, en, ($urandom_range(0, 3) == 0));
  endtask

  initial begin
    rst_n      = 1'b1;
    req_i      = '0;
    port_en_i  = '0;
    fl_empty_i = 1'b0;
    fl_rdata_i = '0;
    fl_next    = 10;
    pend_data  = '0;
    cur_req    = '0;
    prev_gnt   = '0;
    model_reset();
    #1 rst_n = 1'b0;
    do_reset();

    // Prefetch fill with no requests
    for (int c = 0; c < 6; c++) do_cycle(4'b0000, 4'b1111, 1'b0);
    // Single port holding request: every other cycle at best
    for (int c = 0; c < 10; c++) do_cycle(4'b0001, 4'b1111, 1'b0);
    // All ports requesting: rotation
    for (int c = 0; c < 12; c++) do_cycle(4'b1111, 4'b1111, 1'b0);
    // Port 2 masked
    for (int c = 0; c < 12; c++) do_cycle(4'b1111, 4'b1011, 1'b0);
    // Free list empty: drain, wait, then refill
    for (int c = 0; c < 6; c++) do_cycle(4'b0010, 4'b1111, 1'b1);
    for (int c = 0; c < 6; c++) do_cycle(4'b0010, 4'b1111, 1'b0);
    // Reset while a pop is in flight
    do_cycle(4'b1111, 4'b1111, 1'b1);
    do_cycle(4'b1111, 4'b1111, 1'b1);
    for (int c = 0; c < 10 && !m_infl; c++) do_cycle(4'b0000, 4'b1111, 1'b0);
    do_reset();
    for (int c = 0; c < 6; c++) do_cycle(4'b1110, 4'b1111, 1'b0);

    cur_req  = '0;
    prev_gnt = '0;
    for (int c = 0; c < 600; c++) rand_cycle();
    do_reset();
    for (int c = 0; c < 200; c++) rand_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_fl_alloc_arbiter
